multi_servo_pwm: RTL and testbench

//  NUM_CH-channel RC-servo pulse generator sharing one prescaler and frame counter.
//  Per channel: pulse of (MIN_TICKS + position) ticks, once every FRAME_TICKS ticks.

---
 rtl/servo_pkg.sv | 23 ++
 rtl/servo_channel.sv | 80 ++++++++
 rtl/multi_servo_pwm.sv | 83 ++++++++
 tb/tb_multi_servo_pwm.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo pulse generator:
// default timing constants and width helpers.
package servo_pkg;

    localparam int CLK_DIV_50M      = 195;
    localparam int FRAME_TICKS_16MS = 4096;
    localparam int MIN_TICKS_1MS    = 256;

    // Ceiling log2, never below 1 so single-value counters still get a bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // Channel address width with one spare code, so out-of-range
    // channel numbers are representable and can be rejected.
    function automatic int ch_addr_w(input int num_ch);
        return clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: staged/active position, per-frame enable,
// slew-limited frame latch and registered pulse-width compare.
module servo_channel #(
    parameter int POS_W     = 8,
    parameter int FC_W      = 12,
    parameter int MIN_TICKS = 256,
    parameter int SLEW_STEP = 0,
    parameter int RESET_POS = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [FC_W-1:0]  frame_cnt_i,
    input  logic             latch_i,
    input  logic             wr_i,
    input  logic [POS_W-1:0] wr_pos_i,
    input  logic             enable_i,
    output logic             pulse_o
);

    localparam int CMP_W    = ((FC_W > POS_W) ? FC_W : POS_W) + 1;
    localparam int STEP_SAT = (SLEW_STEP >= (1 << POS_W)) ? (1 << POS_W) : SLEW_STEP;

    localparam logic [POS_W:0]   STEP    = (POS_W + 1)'(STEP_SAT);
    localparam logic [POS_W-1:0] RST_POS = POS_W'(RESET_POS);
    localparam logic [CMP_W-1:0] MIN_W   = CMP_W'(MIN_TICKS);

    logic [POS_W-1:0] staged_q, staged_d;
    logic [POS_W-1:0] active_q, active_d;
    logic             en_q, en_d;
    logic             pulse_q, pulse_d;

    logic [POS_W:0]   cur_x;
    logic [POS_W:0]   tgt_x;
    logic [POS_W:0]   delta;
    logic [POS_W:0]   move;
    logic [POS_W:0]   slewed;
    logic             rising;
    logic [CMP_W-1:0] limit;
    logic [CMP_W-1:0] cnt_x;

    // Move toward the target by at most STEP; the extra bit keeps the
    // difference exact so the result can neither overshoot nor wrap.
    always_comb begin
        cur_x  = {1'b0, active_q};
        tgt_x  = {1'b0, staged_q};
        rising = (tgt_x >= cur_x);
        delta  = rising ? (tgt_x - cur_x) : (cur_x - tgt_x);
        move   = delta;
        if (SLEW_STEP != 0 && delta > STEP) begin
            move = STEP;
        end
        slewed = rising ? (cur_x + move) : (cur_x - move);
    end

    always_comb begin
        staged_d = wr_i ? wr_pos_i : staged_q;
        active_d = latch_i ? slewed[POS_W-1:0] : active_q;
        en_d     = latch_i ? enable_i : en_q;
        limit    = MIN_W + CMP_W'(active_q);
        cnt_x    = CMP_W'(frame_cnt_i);
        pulse_d  = en_q && (cnt_x < limit);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            staged_q <= RST_POS;
            active_q <= RST_POS;
            en_q     <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            staged_q <= staged_d;
            active_q <= active_d;
            en_q     <= en_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/multi_servo_pwm.sv
// NUM_CH-channel RC-servo pulse generator: shared prescaler and frame
// counter, addressed position writes, frame-aligned updates per channel.
module multi_servo_pwm
    import servo_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int POS_W       = 8,
    parameter int CLK_DIV     = CLK_DIV_50M,
    parameter int FRAME_TICKS = FRAME_TICKS_16MS,
    parameter int MIN_TICKS   = MIN_TICKS_1MS,
    parameter int SLEW_STEP   = 0,
    parameter int RESET_POS   = 1 << (POS_W - 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ch_addr_w(NUM_CH)-1:0] wr_ch,
    input  logic [POS_W-1:0]             wr_pos,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic [NUM_CH-1:0]            pulse_out,
    output logic                         frame_start
);

    localparam int CH_W  = ch_addr_w(NUM_CH);
    localparam int DIV_W = clog2(CLK_DIV);
    localparam int FC_W  = clog2(FRAME_TICKS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_TICKS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             fs_q, fs_d;
    logic             tick;
    logic [NUM_CH-1:0] wr_sel;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
        fc_d  = fc_q;
        if (tick) begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + FC_W'(1);
        end
        // Registered look-ahead: high during the clk whose closing edge wraps.
        fs_d = (div_d == DIV_LAST) && (fc_d == FC_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            fc_q  <= '0;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            fc_q  <= fc_d;
            fs_q  <= fs_d;
        end
    end

    assign frame_start = fs_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

        servo_channel #(
            .POS_W     (POS_W),
            .FC_W      (FC_W),
            .MIN_TICKS (MIN_TICKS),
            .SLEW_STEP (SLEW_STEP),
            .RESET_POS (RESET_POS)
        ) u_ch (
            .clk_i       (clk),
            .rst_i       (rst),
            .frame_cnt_i (fc_q),
            .latch_i     (fs_q),
            .wr_i        (wr_sel[i]),
            .wr_pos_i    (wr_pos),
            .enable_i    (ch_enable[i]),
            .pulse_o     (pulse_out[i])
        );
    end

endmodule

// File: tb/tb_multi_servo_pwm.sv
// Bench for multi_servo_pwm: jump and slew-limited instances driven
// together and checked per frame against a frame-level position model.
module tb_multi_servo_pwm;

    localparam int NCH  = 4;
    localparam int PW   = 4;
    localparam int CD   = 4;
    localparam int FT   = 64;
    localparam int MT   = 16;
    localparam int RP   = 8;
    localparam int FCLK = CD * FT;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [2:0]    wr_ch;
    logic [PW-1:0] wr_pos;
    logic [NCH-1:0] ch_enable;
    logic [NCH-1:0] po [2];
    logic           fs [2];

    always #5 clk = ~clk;

    multi_servo_pwm #(
        .NUM_CH(NCH), .POS_W(PW), .CLK_DIV(CD), .FRAME_TICKS(FT),
        .MIN_TICKS(MT), .SLEW_STEP(0), .RESET_POS(RP)
    ) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_pos(wr_pos), .ch_enable(ch_enable),
        .pulse_out(po[0]), .frame_start(fs[0])
    );

    multi_servo_pwm #(
        .NUM_CH(NCH), .POS_W(PW), .CLK_DIV(CD), .FRAME_TICKS(FT),
        .MIN_TICKS(MT), .SLEW_STEP(2), .RESET_POS(RP)
    ) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_pos(wr_pos), .ch_enable(ch_enable),
        .pulse_out(po[1]), .frame_start(fs[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level model: positions per instance, enables, expected widths.
    int stg  [2][NCH];
    int act  [2][NCH];
    int expw [2][NCH];
    int hi   [2][NCH];
    int err  [2][NCH];
    int fserr[2];
    int e;

    function automatic int slew_to(input int a, input int s, input int step);
        if (step == 0) return s;
        if (s > a) return (s - a > step) ? a + step : s;
        return (a - s > step) ? a - step : s;
    endfunction

    task automatic model_reset();
        e = 0;
        for (int d = 0; d < 2; d++) begin
            fserr[d] = 0;
            for (int i = 0; i < NCH; i++) begin
                stg[d][i]  = RP;
                act[d][i]  = RP;
                expw[d][i] = 0;
                hi[d][i]   = 0;
                err[d][i]  = 0;
            end
        end
    endtask

    task automatic tick();
        int o;
        @(posedge clk);
        #1;
        e++;
        o = ((e - 1) % FCLK) + 1;
        for (int d = 0; d < 2; d++) begin
            if (fs[d] !== ((e % FCLK) == FCLK - 1)) fserr[d]++;
            for (int i = 0; i < NCH; i++) begin
                if (po[d][i] !== (o <= expw[d][i])) err[d][i]++;
                if (po[d][i] === 1'b1) hi[d][i]++;
            end
        end
        if (o == FCLK) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("f%0d dut%0d frame_start", e / FCLK - 1, d),
                    fserr[d], 0);
                fserr[d] = 0;
                for (int i = 0; i < NCH; i++) begin
                    chk($sformatf("f%0d dut%0d ch%0d width", e / FCLK - 1, d, i),
                        hi[d][i], expw[d][i]);
                    chk($sformatf("f%0d dut%0d ch%0d shape", e / FCLK - 1, d, i),
                        err[d][i], 0);
                    hi[d][i]  = 0;
                    err[d][i] = 0;
                    act[d][i]  = slew_to(act[d][i], stg[d][i], d * 2);
                    expw[d][i] = ch_enable[i] ? (MT + act[d][i]) * CD : 0;
                end
            end
        end
        if (wr_en && wr_ch < NCH) begin
            stg[0][wr_ch] = int'(wr_pos);
            stg[1][wr_ch] = int'(wr_pos);
        end
    endtask

    task automatic go_to(input int target);
        while (e < target) tick();
    endtask

    task automatic write(input int ch, input int pos);
        wr_en  = 1'b1;
        wr_ch  = 3'(ch);
        wr_pos = PW'(pos);
        tick();
        wr_en  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        int idx;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_pos    = '0;
        ch_enable = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset pulse dut0", po[0], 0);
        chk("reset pulse dut1", po[1], 0);
        chk("reset fs dut0", fs[0], 0);
        rst = 1'b0;

        go_to(FCLK + 100);
        write(0, 0);
        write(3, 15);

        go_to(3 * FCLK - 1);
        write(1, 15);

        go_to(4 * FCLK + 50);
        ch_enable[2] = 1'b0;
        go_to(5 * FCLK + 50);
        write(4, 0);
        go_to(6 * FCLK + 30);
        write(3, 14);
        go_to(7 * FCLK + 10);
        ch_enable[2] = 1'b1;

        while (e < 16 * FCLK) begin
            if ($urandom_range(0, 19) == 0 ||
                ((e % FCLK) == FCLK - 1 && $urandom_range(0, 1) == 1)) begin
                wr_en  = 1'b1;
                wr_ch  = 3'($urandom_range(0, 7));
                wr_pos = PW'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) == 0) begin
                idx = $urandom_range(0, NCH - 1);
                ch_enable[idx] = ~ch_enable[idx];
            end
            tick();
            wr_en = 1'b0;
        end

        ch_enable = '1;
        go_to(17 * FCLK + 20);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst pulse dut0", po[0], 0);
        chk("async rst pulse dut1", po[1], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("held rst pulse dut0", po[0], 0);
        chk("held rst fs dut1", fs[1], 0);
        model_reset();
        rst = 1'b0;
        go_to(3 * FCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
